// File: rtl/div.sv
// Iterative 32-bit divider: one quotient bit per clock, restoring shift-subtract.
// Result is {remainder, quotient}; handles signed/unsigned, divide-by-zero and annul.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] rem_q, rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] op1_mag, op2_mag;
  logic [33:0] rem_shift;
  logic        rem_ge;
  logic [31:0] quo_fix, rem_fix;

  assign result_o = result_q;
  assign ready_o  = ready_q;

  always_comb begin
    op1_mag   = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_mag   = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    // Dividend bits are shifted out of the quotient register MSB first.
    rem_shift = {rem_q, quo_q[31]};
    rem_ge    = rem_shift >= {2'b00, divisor_q};
    quo_fix   = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    rem_fix   = neg_rem_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

    state_d   = state_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      StFree: begin
        result_d = 64'h0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          cnt_d     = 6'd0;
          rem_d     = 33'h0;
          quo_d     = op1_mag;
          divisor_d = op2_mag;
          neg_quo_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_d = signed_div_i & opdata1_i[31];
          state_d   = (opdata2_i == 32'h0) ? StByZero : StOn;
        end
      end
      StByZero: begin
        result_d = 64'h0;
        if (annul_i) begin
          ready_d = 1'b0;
          state_d = StFree;
        end else begin
          ready_d = 1'b1;
          state_d = StEnd;
        end
      end
      StOn: begin
        if (annul_i) begin
          result_d = 64'h0;
          ready_d  = 1'b0;
          state_d  = StFree;
        end else if (cnt_q == 6'd32) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = StEnd;
        end else begin
          rem_d = rem_ge ? 33'(rem_shift - {2'b00, divisor_q}) : rem_shift[32:0];
          quo_d = {quo_q[30:0], rem_ge};
          cnt_d = cnt_q + 6'd1;
        end
      end
      StEnd: begin
        // annul_i is deliberately ignored: the result is already committed.
        if (!start_i) begin
          result_d = 64'h0;
          ready_d  = 1'b0;
          state_d  = StFree;
        end
      end
      default: begin
        result_d = 64'h0;
        ready_d  = 1'b0;
        state_d  = StFree;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFree;
      cnt_q     <= 6'd0;
      divisor_q <= 32'h0;
      quo_q     <= 32'h0;
      rem_q     <= 33'h0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'h0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  div u_div (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Plain arithmetic reference; 64-bit signed math makes the overflow case wrap.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Issues a request and checks latency and result; leaves start_i high.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] exp);
    int lat;
    exp = ref_div(sgn, a, b);
    lat = (b == 32'h0) ? 2 : 34;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    for (int e = 1; e <= lat; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom);
      end
      if (e == lat - 1) begin
        check("busy_ready", {63'h0, ready_o}, 64'h0);
        check("busy_result", result_o, 64'h0);
      end
      if (e == lat) begin
        check("ready", {63'h0, ready_o}, 64'h1);
        check("result", result_o, exp);
      end
    end
  endtask

  task automatic release_div();
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("release_ready", {63'h0, ready_o}, 64'h0);
    check("release_result", result_o, 64'h0);
  endtask

  initial begin
    logic [63:0] exp;
    logic [31:0] a, b;
    logic        sgn;

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'h0;
    opdata2_i    = 32'h0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    check("reset_ready", {63'h0, ready_o}, 64'h0);
    check("reset_result", result_o, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, exp);
    check("u100_7", result_o, 64'h00000002_0000000E);
    release_div();

    run_div(1'b1, 32'hFFFFFF9C, 32'd7, exp);
    check("s-100_7", result_o, 64'hFFFFFFFE_FFFFFFF2);
    release_div();

    run_div(1'b0, 32'hFFFFFF9C, 32'd7, exp);
    release_div();

    run_div(1'b0, 32'h12345678, 32'h0, exp);
    check("divz_u", result_o, 64'h0);
    release_div();
    run_div(1'b1, 32'h12345678, 32'h0, exp);
    release_div();

    // Overflow wraps; result must hold while start_i stays high, annul ignored.
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, exp);
    check("ovf", result_o, 64'h00000000_80000000);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        @(negedge clk);
        annul_i = 1'b1;
      end
      @(posedge clk);
      #1;
      check("hold_ready", {63'h0, ready_o}, 64'h1);
      check("hold_result", result_o, 64'h00000000_80000000);
    end
    annul_i = 1'b0;
    release_div();

    // Annul at edge 10 of an active division.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul_ready", {63'h0, ready_o}, 64'h0);
    check("annul_result", result_o, 64'h0);
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("annul_idle", {63'h0, ready_o}, 64'h0);
    end
    run_div(1'b0, 32'd9, 32'd3, exp);
    check("after_annul", result_o, 64'h00000000_00000003);
    release_div();

    // Annul while waiting out a divide-by-zero.
    @(negedge clk);
    opdata1_i = 32'd5;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_byz", {63'h0, ready_o}, 64'h0);
    annul_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_byz_idle", {63'h0, ready_o}, 64'h0);

    // Asynchronous reset mid-iteration, then while a result is held.
    @(negedge clk);
    opdata1_i = 32'd123456;
    opdata2_i = 32'd11;
    start_i   = 1'b1;
    repeat (21) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_on_ready", {63'h0, ready_o}, 64'h0);
    check("rst_on_result", result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_div(1'b0, 32'd50, 32'd5, exp);
    #3;
    rst = 1'b1;
    #1;
    check("rst_end_ready", {63'h0, ready_o}, 64'h0);
    check("rst_end_result", result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_div(1'b1, 32'hFFFFFFF9, 32'd2, exp);
    release_div();

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom);
      a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_div(sgn, a, b, exp);
      release_div();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
